csp_channel: RTL and testbench

- Synthesizable, clocked point-to-point 4-phase bundled-data (P4PhaseBD) channel.
- Carries one WIDTH-bit token from a single sender to a single receiver through a one-entry holding buffer.
- Used wherever the memory controller links its memory model, memory interface and NoC ports, e.g. the 9-wide internal channel array at WIDTH=64.
- Decouples sender and receiver handshakes: each side sees a complete, independent 4-phase cycle per token.

---
 rtl/csp_channel_pkg.sv | 18 +
 rtl/csp_channel_if.sv | 28 ++
 rtl/csp_channel.sv | 109 ++++++++++
 tb/tb_csp_channel.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/csp_channel_pkg.sv
// Shared types and defaults for the 4-phase bundled-data channel.
// Send and receive state encodings live here so the bench and RTL agree on names.
package csp_channel_pkg;

  localparam int CSP_WIDTH = 64;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } snd_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RTZ  = 2'd2
  } rcv_state_e;

endpackage

// File: rtl/csp_channel_if.sv
// Handshake bundle for one channel: sender side, receiver side and status.
// slave is the channel itself; master is whoever drives the sender and receiver.
interface csp_channel_if
  import csp_channel_pkg::*;
#(
  parameter int WIDTH = CSP_WIDTH
) ();

  logic             s_req;
  logic [WIDTH-1:0] s_data;
  logic             s_ack;
  logic             r_req;
  logic [WIDTH-1:0] r_data;
  logic             r_ack;
  logic             full;
  logic             proto_err;

  modport slave (
    input  s_req, s_data, r_ack,
    output s_ack, r_req, r_data, full, proto_err
  );

  modport master (
    output s_req, s_data, r_ack,
    input  s_ack, r_req, r_data, full, proto_err
  );

endinterface

// File: rtl/csp_channel.sv
// One-entry 4-phase bundled-data channel: independent send and receive FSMs
// around a single holding buffer, plus a sticky handshake-violation flag.
//
// state  | meaning
// S_IDLE | waiting for s_req with the buffer empty
// S_ACK  | token captured, s_ack high until sender returns s_req to zero
// R_IDLE | no token offered to the receiver
// R_REQ  | r_req high, r_data valid, waiting for r_ack
// R_RTZ  | buffer freed, waiting for r_ack to return to zero
module csp_channel
  import csp_channel_pkg::*;
#(
  parameter int WIDTH = CSP_WIDTH
) (
  input logic          clk,
  input logic          rst,
  csp_channel_if.slave ch
);

  snd_state_e       snd_q, snd_d;
  rcv_state_e       rcv_q, rcv_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             err_q, err_d;
  logic             sreq_q;
  logic [WIDTH-1:0] sdata_q;
  logic             wd_q, wd_d;
  logic             capture;
  logic             release_tok;
  logic             viol;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snd_q   <= S_IDLE;
      rcv_q   <= R_IDLE;
      full_q  <= 1'b0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      sreq_q  <= 1'b0;
      sdata_q <= '0;
      wd_q    <= 1'b0;
    end else begin
      snd_q   <= snd_d;
      rcv_q   <= rcv_d;
      full_q  <= full_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      sreq_q  <= ch.s_req;
      sdata_q <= ch.s_data;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    snd_d       = snd_q;
    rcv_d       = rcv_q;
    full_d      = full_q;
    buf_d       = buf_q;
    capture     = 1'b0;
    release_tok = 1'b0;

    // Capture looks only at registered full, so set and clear never share an edge.
    unique case (snd_q)
      S_IDLE: if (ch.s_req && !full_q) begin
        snd_d   = S_ACK;
        capture = 1'b1;
      end
      S_ACK:  if (!ch.s_req) snd_d = S_IDLE;
      default: snd_d = S_IDLE;
    endcase

    unique case (rcv_q)
      R_IDLE: if (full_q && !ch.r_ack) rcv_d = R_REQ;
      R_REQ:  if (ch.r_ack) begin
        rcv_d       = R_RTZ;
        release_tok = 1'b1;
      end
      R_RTZ:  if (!ch.r_ack) rcv_d = R_IDLE;
      default: rcv_d = R_IDLE;
    endcase

    if (capture) begin
      full_d = 1'b1;
      buf_d  = ch.s_data;
    end else if (release_tok) begin
      full_d = 1'b0;
    end
  end

  // Violation checks observe only; they never steer the FSMs.
  always_comb begin
    wd_d = (snd_q == S_IDLE) && ch.s_req && !full_q;
    viol = 1'b0;
    if ((rcv_q == R_IDLE) && ch.r_ack)
      viol = 1'b1;
    if ((snd_q == S_IDLE) && wd_q && !ch.s_req)
      viol = 1'b1;
    if ((snd_q == S_IDLE) && ch.s_req && sreq_q && !full_q && (ch.s_data != sdata_q))
      viol = 1'b1;
    err_d = err_q | viol;
  end

  assign ch.s_ack     = (snd_q == S_ACK);
  assign ch.r_req     = (rcv_q == R_REQ);
  assign ch.r_data    = buf_q;
  assign ch.full      = full_q;
  assign ch.proto_err = err_q;

endmodule

// File: tb/tb_csp_channel.sv
// Self-checking bench for csp_channel: directed latency/backpressure/reset cases
// plus a randomized token stream checked against an in-order token queue.
module tb_csp_channel;
  import csp_channel_pkg::*;

  localparam int W     = 64;
  localparam int LIMIT = 60;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rcvd  = 0;
  logic [W-1:0] exp_q[$];

  csp_channel_if #(.WIDTH(W)) bus ();

  csp_channel #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .ch  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_token(input logic [W-1:0] data);
    int n;
    n = 0;
    while (bus.s_ack && n < LIMIT) begin step(); n++; end
    bus.s_data = data;
    bus.s_req  = 1'b1;
    exp_q.push_back(data);
    n = 0;
    while (!bus.s_ack && n < LIMIT) begin step(); n++; end
    chk("send_ack_seen", {63'd0, bus.s_ack}, 64'd1);
    bus.s_req = 1'b0;
    n = 0;
    while (bus.s_ack && n < LIMIT) begin step(); n++; end
  endtask

  task automatic recv_token(input int dly);
    int n;
    n = 0;
    while (!bus.r_req && n < LIMIT) begin step(); n++; end
    chk("recv_req_seen", {63'd0, bus.r_req}, 64'd1);
    if (bus.r_req) begin
      if (exp_q.size() == 0) chk("recv_unexpected_token", 64'd1, 64'(exp_q.size()));
      else chk("recv_data", bus.r_data, exp_q.pop_front());
      n_rcvd++;
      repeat (dly) step();
      bus.r_ack = 1'b1;
      n = 0;
      while (bus.r_req && n < LIMIT) begin step(); n++; end
      bus.r_ack = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] tok;
    rst        = 1'b1;
    bus.s_req  = 1'b0;
    bus.s_data = '0;
    bus.r_ack  = 1'b0;
    #12;
    chk("rst_s_ack", {63'd0, bus.s_ack}, 64'd0);
    chk("rst_r_req", {63'd0, bus.r_req}, 64'd0);
    chk("rst_full",  {63'd0, bus.full}, 64'd0);
    chk("rst_err",   {63'd0, bus.proto_err}, 64'd0);
    chk("rst_r_data", bus.r_data, 64'd0);
    rst = 1'b0;
    step();

    // single token with exact latency
    tok = 64'h0010_0400_0000_1F3A;
    bus.s_data = tok;
    bus.s_req  = 1'b1;
    step();
    chk("single_s_ack_k", {63'd0, bus.s_ack}, 64'd1);
    chk("single_full_k",  {63'd0, bus.full}, 64'd1);
    chk("single_r_req_k", {63'd0, bus.r_req}, 64'd0);
    step();
    chk("single_r_req_k1", {63'd0, bus.r_req}, 64'd1);
    chk("single_r_data", bus.r_data, tok);
    bus.r_ack = 1'b1;
    step();
    chk("single_full_clr", {63'd0, bus.full}, 64'd0);
    chk("single_r_req_drop", {63'd0, bus.r_req}, 64'd0);
    bus.s_req = 1'b0;
    bus.r_ack = 1'b0;
    step();
    chk("single_s_ack_idle", {63'd0, bus.s_ack}, 64'd0);
    chk("single_r_req_idle", {63'd0, bus.r_req}, 64'd0);
    step();
    chk("single_r_req_no_dup", {63'd0, bus.r_req}, 64'd0);

    // backpressure: B waits until A is acked
    bus.s_data = 64'h1;
    bus.s_req  = 1'b1;
    exp_q.push_back(64'h1);
    step();
    chk("bp_ack_a", {63'd0, bus.s_ack}, 64'd1);
    bus.s_req = 1'b0;
    step();
    bus.s_data = 64'h2;
    bus.s_req  = 1'b1;
    exp_q.push_back(64'h2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_b", {63'd0, bus.s_ack}, 64'd0);
    end
    chk("bp_r_req_a", {63'd0, bus.r_req}, 64'd1);
    chk("bp_data_a", bus.r_data, exp_q.pop_front());
    bus.r_ack = 1'b1;
    step();
    chk("bp_full_clr", {63'd0, bus.full}, 64'd0);
    chk("bp_b_waits_clear_edge", {63'd0, bus.s_ack}, 64'd0);
    step();
    chk("bp_ack_b", {63'd0, bus.s_ack}, 64'd1);
    chk("bp_full_b", {63'd0, bus.full}, 64'd1);
    chk("bp_no_req_while_ack", {63'd0, bus.r_req}, 64'd0);
    bus.r_ack = 1'b0;
    bus.s_req = 1'b0;
    step();
    step();
    chk("bp_r_req_b", {63'd0, bus.r_req}, 64'd1);
    chk("bp_data_b", bus.r_data, exp_q.pop_front());
    bus.r_ack = 1'b1;
    step();
    bus.r_ack = 1'b0;
    step();
    step();
    chk("bp_no_dup", {63'd0, bus.r_req}, 64'd0);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // randomized stream of alternating one-bit tokens
    n_rcvd = 0;
    fork
      begin
        for (int i = 0; i < 625; i++) send_token(64'(i % 2));
      end
      begin
        for (int j = 0; j < 625; j++) recv_token(int'($urandom_range(0, 3)));
      end
    join
    chk("stream_count", 64'(n_rcvd), 64'd625);
    chk("stream_leftover", 64'(exp_q.size()), 64'd0);
    chk("stream_err", {63'd0, bus.proto_err}, 64'd0);
    step();

    // async reset while r_req is high
    tok = 64'hDEAD_BEEF_0123_4567;
    bus.s_data = tok;
    bus.s_req  = 1'b1;
    step();
    step();
    chk("ares_pre_r_req", {63'd0, bus.r_req}, 64'd1);
    chk("ares_pre_s_ack", {63'd0, bus.s_ack}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ares_s_ack", {63'd0, bus.s_ack}, 64'd0);
    chk("ares_r_req", {63'd0, bus.r_req}, 64'd0);
    chk("ares_full",  {63'd0, bus.full}, 64'd0);
    chk("ares_r_data", bus.r_data, 64'd0);
    bus.s_req = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    step();
    chk("ares_idle_r_req", {63'd0, bus.r_req}, 64'd0);
    fork
      send_token(64'hFFFF_FFFF_FFFF_FFFF);
      recv_token(1);
    join
    chk("ares_leftover", 64'(exp_q.size()), 64'd0);
    step();

    // protocol violation: r_ack with nothing pending
    chk("viol_pre_err", {63'd0, bus.proto_err}, 64'd0);
    bus.r_ack = 1'b1;
    step();
    chk("viol_err_set", {63'd0, bus.proto_err}, 64'd1);
    chk("viol_no_r_req", {63'd0, bus.r_req}, 64'd0);
    bus.r_ack = 1'b0;
    step();
    step();
    chk("viol_err_sticky", {63'd0, bus.proto_err}, 64'd1);
    fork
      send_token(64'hA5A5_0000_FFFF_5A5A);
      recv_token(2);
    join
    chk("viol_fsm_ok", 64'(exp_q.size()), 64'd0);
    chk("viol_err_still", {63'd0, bus.proto_err}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("viol_err_rst", {63'd0, bus.proto_err}, 64'd0);
    #3;
    rst = 1'b0;
    step();
    chk("viol_err_after_rst", {63'd0, bus.proto_err}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
